// File: rtl/rcosc_freq_monitor_pkg.sv
// Shared types and default sizing for the RC oscillator frequency monitor.
package rcosc_mon_pkg;

  localparam int unsigned DEF_CNT_W       = 20;
  localparam int unsigned DEF_NUM_PERIODS = 1000;
  localparam int unsigned DEF_LIMIT_LO    = 156800;
  localparam int unsigned DEF_LIMIT_HI    = 163200;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_e;

endpackage

// File: rtl/rcosc_freq_monitor_if.sv
// Control inputs and measurement results of the frequency monitor.
interface rcosc_freq_monitor_if #(
  parameter int unsigned CNT_W = rcosc_mon_pkg::DEF_CNT_W
);

  logic             en;
  logic             ref_in;
  logic             fault_clr;
  logic [CNT_W-1:0] meas_count;
  logic             meas_valid;
  logic             freq_ok;
  logic             freq_fault;
  logic             ref_lost;

  modport master (
    output en, ref_in, fault_clr,
    input  meas_count, meas_valid, freq_ok, freq_fault, ref_lost
  );

  modport slave (
    input  en, ref_in, fault_clr,
    output meas_count, meas_valid, freq_ok, freq_fault, ref_lost
  );

endinterface

// File: rtl/rcosc_freq_monitor_sync_edge_det.sv
// Two-flop synchronizer for the asynchronous reference plus a rising-edge pulse.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise_c
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Synchronizer chain; r_s3 is the delayed copy used for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise_c = r_s2 & ~r_s3;

endmodule

// File: rtl/rcosc_freq_monitor.sv
// Counts local clock cycles across NUM_PERIODS reference periods and flags
// out-of-range oscillator frequency or a missing reference.
module rcosc_freq_monitor
  import rcosc_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned NUM_PERIODS = DEF_NUM_PERIODS,
  parameter int unsigned LIMIT_LO    = DEF_LIMIT_LO,
  parameter int unsigned LIMIT_HI    = DEF_LIMIT_HI
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  rcosc_freq_monitor_if.slave  if_mon
);

  localparam int unsigned      EDGE_W    = $clog2(NUM_PERIODS + 1);
  localparam logic [CNT_W-1:0] CYC_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LIM_LO    = CNT_W'(LIMIT_LO);
  localparam logic [CNT_W-1:0] LIM_HI    = CNT_W'(LIMIT_HI);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(NUM_PERIODS - 1);

  state_e            r_state,  w_state_nxt;
  logic [CNT_W-1:0]  r_cyc,    w_cyc_nxt;
  logic [EDGE_W-1:0] r_edge,   w_edge_nxt;
  logic [CNT_W-1:0]  r_count,  w_count_nxt;
  logic              r_valid,  w_valid_nxt;
  logic              r_ok,     w_ok_nxt;
  logic              r_fault,  w_fault_nxt;
  logic              r_lost,   w_lost_nxt;
  logic [CNT_W-1:0]  w_close_cnt;
  logic              w_in_range;
  logic              w_rise;

  sync_edge_det u_sync (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_async  (if_mon.ref_in),
    .o_rise_c (w_rise)
  );

  // Next-state, counter and verdict logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_edge_nxt  = r_edge;
    w_count_nxt = r_count;
    w_valid_nxt = 1'b0;
    w_ok_nxt    = r_ok;
    w_fault_nxt = r_fault;
    w_lost_nxt  = r_lost;

    // Saturating so a closing edge on the last count value cannot wrap to 0.
    w_close_cnt = (r_cyc == CYC_MAX) ? CYC_MAX : r_cyc + CNT_W'(1);
    w_in_range  = (w_close_cnt >= LIM_LO) && (w_close_cnt <= LIM_HI);

    // Clear first so a same-cycle out-of-range result overrides it.
    if (if_mon.fault_clr) begin
      w_fault_nxt = 1'b0;
    end

    if (!if_mon.en) begin
      w_state_nxt = ST_IDLE;
      w_cyc_nxt   = '0;
      w_edge_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ARM;
          w_cyc_nxt   = '0;
          w_edge_nxt  = '0;
        end
        ST_ARM: begin
          if (w_rise) begin
            w_state_nxt = ST_MEAS;
            w_cyc_nxt   = '0;
            w_edge_nxt  = '0;
          end
        end
        ST_MEAS: begin
          if (w_rise && (r_edge == LAST_EDGE)) begin
            // Closing edge doubles as the opening edge of the next window.
            w_count_nxt = w_close_cnt;
            w_valid_nxt = 1'b1;
            w_ok_nxt    = w_in_range;
            w_lost_nxt  = 1'b0;
            if (!w_in_range) begin
              w_fault_nxt = 1'b1;
            end
            w_cyc_nxt   = '0;
            w_edge_nxt  = '0;
          end else if (r_cyc == CYC_MAX) begin
            w_lost_nxt  = 1'b1;
            w_ok_nxt    = 1'b0;
            w_state_nxt = ST_ARM;
            w_cyc_nxt   = '0;
            w_edge_nxt  = '0;
          end else begin
            w_cyc_nxt = r_cyc + CNT_W'(1);
            if (w_rise) begin
              w_edge_nxt = r_edge + EDGE_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cyc_nxt   = '0;
          w_edge_nxt  = '0;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cyc   <= '0;
      r_edge  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_ok    <= 1'b0;
      r_fault <= 1'b0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_edge  <= w_edge_nxt;
      r_count <= w_count_nxt;
      r_valid <= w_valid_nxt;
      r_ok    <= w_ok_nxt;
      r_fault <= w_fault_nxt;
      r_lost  <= w_lost_nxt;
    end
  end

  assign if_mon.meas_count = r_count;
  assign if_mon.meas_valid = r_valid;
  assign if_mon.freq_ok    = r_ok;
  assign if_mon.freq_fault = r_fault;
  assign if_mon.ref_lost   = r_lost;

endmodule
